// File: rtl/ml_hardbit_serializer.sv
// ml_hardbit_serializer
//
// Output buffer between the ML demodulator datapath and the chip read port.
// Whole hard-decision words arrive on a one-cycle strobe and are queued in a
// DEPTH-word FIFO. The head word is moved into an active-word register and
// streamed out OUT_WIDTH bits per transfer under a valid/ready handshake.
//
// Parameters
//   DATA_WIDTH : hard-bit word width
//   DEPTH      : FIFO storage words (power of two, >= 2)
//   OUT_WIDTH  : bits per output transfer (must divide DATA_WIDTH)
//   LSB_FIRST  : 1 = slice [OUT_WIDTH-1:0] first, 0 = top slice first
//
// Ports
//   i_clk        : clock, all logic on the rising edge
//   i_reset      : synchronous active-high reset (same effect as i_flush)
//   i_x_valid    : one-cycle strobe, i_x_hard_bit carries a new word
//   i_x_hard_bit : hard-bit word from the demodulator
//   i_rd_rdy     : downstream ready
//   i_flush      : synchronous clear of all buffered data and of o_overflow
//   o_rd_vld     : o_hard_bit holds a valid slice (high exactly in STREAM)
//   o_hard_bit   : current output slice, 0 while o_rd_vld is low
//   o_count      : words held in FIFO storage, active word not included
//   o_full       : o_count == DEPTH
//   o_empty      : FIFO empty and no active word
//   o_overflow   : sticky, a word was dropped since the last reset/flush
//
// Handshake: a slice transfers in every cycle where o_rd_vld && i_rd_rdy.
// While i_rd_rdy is low the slice and its counter hold. o_rd_vld never
// depends combinationally on i_rd_rdy.
//
// The output-stage FSM state is visible on o_rd_vld (IDLE = 0, STREAM = 1).

module ml_hardbit_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int OUT_WIDTH  = 1,
  parameter int LSB_FIRST  = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_x_valid,
  input  logic [DATA_WIDTH-1:0]    i_x_hard_bit,
  input  logic                     i_rd_rdy,
  input  logic                     i_flush,
  output logic                     o_rd_vld,
  output logic [OUT_WIDTH-1:0]     o_hard_bit,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_overflow
);

  localparam int NSLICE = DATA_WIDTH / OUT_WIDTH;
  localparam int SW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;

  localparam logic [SW-1:0] LAST_SLICE = SW'(NSLICE - 1);
  localparam logic [CW-1:0] DEPTH_CNT  = CW'(DEPTH);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t                state;
  state_t                state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  // Active word kept as a shift register: the outgoing slice always sits at
  // the bottom (LSB first) or the top (MSB first), so no wide mux is needed.
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_shifted;
  logic [SW-1:0]         slice_cnt;

  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  xfer;
  logic                  last_xfer;
  logic                  load_slot;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic [CW-1:0]         count_nxt;
  logic [OUT_WIDTH-1:0]  lsb_slice;
  logic [OUT_WIDTH-1:0]  msb_slice;

  // ---------------------------------------------------------------------
  // Next-state decode
  // ---------------------------------------------------------------------
  always_comb begin
    fifo_empty = (o_count == '0);
    fifo_full  = (o_count == DEPTH_CNT);

    xfer      = (state == ST_STREAM) && i_rd_rdy;
    last_xfer = xfer && (slice_cnt == LAST_SLICE);

    // The active register can take a new word when it is empty or when its
    // last slice leaves this cycle; this is what keeps back-to-back words
    // free of bubbles.
    load_slot = (state == ST_IDLE) || last_xfer;
    pop       = load_slot && !fifo_empty;

    // A pop in the same cycle frees a slot, so a write at full is accepted.
    push = i_x_valid && (!fifo_full || pop);
    drop = i_x_valid && !push;

    count_nxt = o_count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

    state_nxt = state;
    if (pop) begin
      state_nxt = ST_STREAM;
    end else if (load_slot) begin
      state_nxt = ST_IDLE;
    end

    if (LSB_FIRST != 0) begin
      shreg_shifted = shreg >> OUT_WIDTH;
    end else begin
      shreg_shifted = shreg << OUT_WIDTH;
    end
  end

  // ---------------------------------------------------------------------
  // FSM, pointers, counters and status
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      // Flush outranks any same-cycle write or transfer: the write is
      // discarded without touching o_overflow and the partial word is lost.
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_count    <= '0;
      o_full     <= 1'b0;
      o_empty    <= 1'b1;
      o_overflow <= 1'b0;
      shreg      <= '0;
      slice_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      o_count <= count_nxt;
      o_full  <= (count_nxt == DEPTH_CNT);
      o_empty <= (count_nxt == '0) && (state_nxt == ST_IDLE);

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (drop) begin
        o_overflow <= 1'b1;
      end

      if (pop) begin
        shreg     <= mem[rd_ptr];
        slice_cnt <= '0;
      end else if (last_xfer) begin
        // Word finished with nothing queued behind it.
        shreg     <= '0;
        slice_cnt <= '0;
      end else if (xfer) begin
        shreg     <= shreg_shifted;
        slice_cnt <= slice_cnt + 1'b1;
      end
    end
  end

  // Storage array needs no reset; the pointers define what is valid.
  // When full with a simultaneous pop, wr_ptr == rd_ptr: the head is read
  // into shreg on the same edge the new word overwrites it, which is safe.
  always_ff @(posedge i_clk) begin
    if (push && !i_reset && !i_flush) begin
      mem[wr_ptr] <= i_x_hard_bit;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign lsb_slice = shreg[OUT_WIDTH-1:0];
  assign msb_slice = shreg[DATA_WIDTH-1 -: OUT_WIDTH];

  assign o_rd_vld   = (state == ST_STREAM);
  assign o_hard_bit = !o_rd_vld      ? '0 :
                      (LSB_FIRST != 0) ? lsb_slice : msb_slice;

endmodule

// File: tb/tb_ml_hardbit_serializer.sv
// Directed testbench for ml_hardbit_serializer.
// Two instances: u_dut with default parameters (1-bit slices, LSB first) and
// u_w4 with 4-bit slices, MSB first. Inputs are driven 1 ns after the rising
// edge and outputs are sampled at the same point, away from the edge.

module tb_ml_hardbit_serializer;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Default instance signals
  logic       x_valid;
  logic [7:0] x_hard_bit;
  logic       rd_rdy;
  logic       flush;
  logic       rd_vld;
  logic [0:0] hard_bit;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;

  // 4-bit slice, MSB-first instance signals
  logic       w4_x_valid;
  logic [7:0] w4_x_hard_bit;
  logic       w4_rd_rdy;
  logic       w4_flush;
  logic       w4_rd_vld;
  logic [3:0] w4_hard_bit;
  logic [4:0] w4_count;
  logic       w4_full;
  logic       w4_empty;
  logic       w4_overflow;

  ml_hardbit_serializer u_dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_x_valid    (x_valid),
    .i_x_hard_bit (x_hard_bit),
    .i_rd_rdy     (rd_rdy),
    .i_flush      (flush),
    .o_rd_vld     (rd_vld),
    .o_hard_bit   (hard_bit),
    .o_count      (count),
    .o_full       (full),
    .o_empty      (empty),
    .o_overflow   (overflow)
  );

  ml_hardbit_serializer #(
    .DATA_WIDTH (8),
    .DEPTH      (16),
    .OUT_WIDTH  (4),
    .LSB_FIRST  (0)
  ) u_w4 (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_x_valid    (w4_x_valid),
    .i_x_hard_bit (w4_x_hard_bit),
    .i_rd_rdy     (w4_rd_rdy),
    .i_flush      (w4_flush),
    .o_rd_vld     (w4_rd_vld),
    .o_hard_bit   (w4_hard_bit),
    .o_count      (w4_count),
    .o_full       (w4_full),
    .o_empty      (w4_empty),
    .o_overflow   (w4_overflow)
  );

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] w);
    x_valid    = 1'b1;
    x_hard_bit = w;
    tick();
    x_valid    = 1'b0;
    x_hard_bit = '0;
  endtask

  // Stream with ready high and rebuild LSB-first words from the bits; each
  // rebuilt word is compared against the head of exp_q.
  task automatic drain_words(input int n_words, input int budget);
    logic [7:0] acc;
    int bitpos;
    int got;
    acc    = '0;
    bitpos = 0;
    got    = 0;
    rd_rdy = 1'b1;
    for (int c = 0; c < budget && got < n_words; c++) begin
      if (rd_vld) begin
        acc[bitpos] = hard_bit[0];
        bitpos++;
        if (bitpos == 8) begin
          if (exp_q.size() > 0) chk("drain_word", acc, exp_q.pop_front());
          else                  chk("drain_extra_word", acc, 32'hDEAD);
          got++;
          bitpos = 0;
        end
      end
      tick();
    end
    chk("drain_word_count", got, n_words);
  endtask

  // ---------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  logic [7:0] bits_a;
  logic [7:0] bp_word;
  logic       prev_vld;
  logic       prev_bit;
  int         ntx;

  initial begin
    reset         = 1'b1;
    x_valid       = 1'b0;
    x_hard_bit    = '0;
    rd_rdy        = 1'b0;
    flush         = 1'b0;
    w4_x_valid    = 1'b0;
    w4_x_hard_bit = '0;
    w4_rd_rdy     = 1'b0;
    w4_flush      = 1'b0;

    // ---- reset state ----
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_rd_vld",   rd_vld,   0);
    chk("rst_hard_bit", hard_bit, 0);
    chk("rst_count",    count,    0);
    chk("rst_full",     full,     0);
    chk("rst_empty",    empty,    1);
    chk("rst_overflow", overflow, 0);

    // ---- single word, 2-cycle latency, LSB-first bits ----
    rd_rdy = 1'b1;
    write_word(8'b10010101);
    chk("t1_vld_after_write", rd_vld, 0);
    chk("t1_count_after_write", count, 1);
    chk("t1_empty_after_write", empty, 0);
    tick();
    chk("t1_count_loaded", count, 0);
    bits_a = 8'b10010101;  // expected stream 1,0,1,0,1,0,0,1
    for (int i = 0; i < 8; i++) begin
      chk("t1_vld", rd_vld, 1);
      chk("t1_bit", hard_bit, bits_a[i]);
      tick();
    end
    chk("t1_vld_end", rd_vld, 0);
    chk("t1_empty_end", empty, 1);

    // ---- back-pressure with ready 1,0,0,1,0,0,... ----
    rd_rdy = 1'b0;
    write_word(8'hAE);
    tick();
    chk("bp_vld_start", rd_vld, 1);
    ntx     = 0;
    bp_word = '0;
    for (int c = 0; c < 40; c++) begin
      rd_rdy   = (c % 3 == 0);
      prev_vld = rd_vld;
      prev_bit = hard_bit[0];
      if (rd_vld && rd_rdy) begin
        if (ntx < 8) bp_word[ntx] = hard_bit[0];
        ntx++;
      end
      tick();
      if (prev_vld && !rd_rdy) begin
        chk("bp_hold_bit", hard_bit, prev_bit);
        chk("bp_hold_vld", rd_vld, 1);
      end
    end
    chk("bp_word", bp_word, 8'hAE);
    chk("bp_transfers", ntx, 8);
    chk("bp_vld_end", rd_vld, 0);
    chk("bp_empty_end", empty, 1);

    // ---- fill to full, overflow, ordered drain ----
    rd_rdy = 1'b0;
    for (int i = 0; i < 17; i++) begin
      write_word(8'(i));
      exp_q.push_back(8'(i));
    end
    chk("fill_count_16", count, 16);
    chk("fill_full", full, 1);
    chk("fill_no_overflow", overflow, 0);
    write_word(8'd17);
    chk("fill_overflow_set", overflow, 1);
    chk("fill_count_held", count, 16);
    drain_words(17, 200);
    chk("fill_drained_empty", empty, 1);
    chk("fill_overflow_sticky", overflow, 1);
    rd_rdy = 1'b0;
    flush  = 1'b1;
    tick();
    flush  = 1'b0;
    chk("clr_overflow", overflow, 0);
    chk("clr_empty", empty, 1);

    // ---- full + simultaneous pop accepts the write ----
    for (int i = 0; i < 17; i++) begin
      write_word(8'(8'h20 + i));
      if (i > 0) exp_q.push_back(8'(8'h20 + i));
    end
    chk("fp_count_16", count, 16);
    chk("fp_full", full, 1);
    rd_rdy = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("fp_vld_last_slice", rd_vld, 1);
    write_word(8'hFF);  // lands on the edge where slice 7 transfers
    exp_q.push_back(8'hFF);
    chk("fp_count_stays_16", count, 16);
    chk("fp_full_stays", full, 1);
    chk("fp_no_overflow", overflow, 0);
    drain_words(17, 200);
    chk("fp_empty_end", empty, 1);

    // ---- flush mid-word with 5 queued and overflow set ----
    rd_rdy = 1'b0;
    for (int i = 0; i < 18; i++) write_word(8'(i));
    chk("fl_overflow_set", overflow, 1);
    chk("fl_count_16", count, 16);
    rd_rdy = 1'b1;
    for (int i = 0; i < 88; i++) tick();  // words 0..10 fully sent
    chk("fl_count_5", count, 5);
    for (int i = 0; i < 3; i++) tick();
    chk("fl_slice3_vld", rd_vld, 1);
    chk("fl_slice3_bit", hard_bit, 1);  // bit 3 of 8'h0B
    flush      = 1'b1;
    x_valid    = 1'b1;
    x_hard_bit = 8'h77;
    tick();
    flush      = 1'b0;
    x_valid    = 1'b0;
    chk("fl_vld", rd_vld, 0);
    chk("fl_count", count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_overflow_clr", overflow, 0);
    chk("fl_full_clr", full, 0);
    chk("fl_hard_bit_zero", hard_bit, 0);
    tick();
    tick();
    chk("fl_write_lost_vld", rd_vld, 0);
    chk("fl_write_lost_count", count, 0);
    chk("fl_write_lost_empty", empty, 1);

    // ---- 4-bit slices, MSB first, back-to-back words ----
    w4_rd_rdy     = 1'b1;
    w4_x_valid    = 1'b1;
    w4_x_hard_bit = 8'hA5;
    tick();
    w4_x_hard_bit = 8'h3C;
    chk("w4_vld_latency", w4_rd_vld, 0);
    tick();
    w4_x_valid    = 1'b0;
    w4_x_hard_bit = '0;
    chk("w4_vld0", w4_rd_vld, 1);
    chk("w4_slice_a", w4_hard_bit, 4'hA);
    tick();
    chk("w4_slice_5", w4_hard_bit, 4'h5);
    tick();
    chk("w4_no_gap_vld", w4_rd_vld, 1);
    chk("w4_slice_3", w4_hard_bit, 4'h3);
    tick();
    chk("w4_slice_c", w4_hard_bit, 4'hC);
    tick();
    chk("w4_vld_end", w4_rd_vld, 0);
    chk("w4_empty_end", w4_empty, 1);
    chk("w4_overflow", w4_overflow, 0);

    // ---- final report ----
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ml_hardbit_serializer.md
# ml_hardbit_serializer

Parametrised output buffer between the ML demodulator datapath and the chip read port. It accepts whole hard-decision words on a single-cycle valid strobe, queues them in a DEPTH-word FIFO, and streams each word out OUT_WIDTH bits at a time under a valid/ready handshake. Compared with the fixed 8-bit, 1-bit-serial controller it replaces, it adds:
- selectable slice width and bit order;
- occupancy, full and empty status;
- sticky overflow detection;
- a synchronous flush.

## Interface
- DATA_WIDTH, 8: hard-bit word width.
- DEPTH, 16: FIFO storage words; power of two, ≥2.
- OUT_WIDTH, 1: bits per output transfer; must divide DATA_WIDTH.
- LSB_FIRST, 1: 1 = slice [OUT_WIDTH-1:0] first; 0 = top slice first.

- i_clk  in  1  single clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_x_valid  in  1  one-cycle strobe; i_x_hard_bit is a new word.
- i_x_hard_bit  in  DATA_WIDTH  hard-bit word from demodulator.
- i_rd_rdy  in  1  downstream ready.
- i_flush  in  1  synchronous clear of all buffered data.
- o_rd_vld  out  1  o_hard_bit holds a valid slice.
- o_hard_bit  out  OUT_WIDTH  current output slice; 0 when o_rd_vld=0.
- o_count  out  $clog2(DEPTH)+1  words in FIFO storage, excluding the active word.
- o_full  out  1  o_count == DEPTH.
- o_empty  out  1  FIFO empty and no active word.
- o_overflow  out  1  sticky; a word was dropped.

## Operation
- Storage consists of the FIFO (DEPTH words) plus one active-word register with a slice counter (0..DATA_WIDTH/OUT_WIDTH-1). Total capacity is DEPTH+1 words.
- Output stage has two states:
  - IDLE: no active word; o_rd_vld=0.
  - STREAM: active word loaded; o_rd_vld=1.
- A transfer occurs in any cycle with o_rd_vld && i_rd_rdy. On a transfer the slice counter increments. o_hard_bit and the counter hold while i_rd_rdy=0.
- Load rule: in IDLE, or in STREAM on the transfer of the last slice:
  - if the FIFO is non-empty, pop its head into the active register, reset the counter to 0 and enter or stay in STREAM;
  - otherwise go to IDLE.
- Write rule: if i_x_valid is high and the FIFO is not full, or a pop occurs in the same cycle, push i_x_hard_bit. Otherwise drop the word and set o_overflow.
- Slice k is bits [k*OUT_WIDTH +: OUT_WIDTH] when LSB_FIRST=1. When LSB_FIRST=0 the order is reversed (slice index counts from the top).
- Flush (i_flush=1) empties the FIFO and active register, returns to IDLE and clears o_overflow.
  - It has priority over a same-cycle write, which is discarded without setting overflow.
  - It has priority over a same-cycle transfer.
- Reset behaves as flush. All outputs are 0 except o_empty=1. Counters and pointers are 0.
- Pointers wrap modulo DEPTH. o_count is computed from push/pop and never exceeds DEPTH.

## Timing
- Write accepted at edge t into a fully empty block: the word enters the FIFO. At edge t+1 it loads into the active register. o_rd_vld=1 from cycle t+2, so first-slice latency is 2 cycles.
- Back-to-back words stream without a bubble: with i_rd_rdy held high and the FIFO non-empty, the last slice of word n is followed by slice 0 of word n+1 in the next cycle.
- Throughput is one slice per cycle. A word therefore occupies DATA_WIDTH/OUT_WIDTH ready cycles.
- o_count, o_full, o_empty and o_overflow are registered and reflect state after the edge.
- Simultaneous push and pop leaves o_count unchanged, including at DEPTH.
- i_flush or i_reset asserted mid-word: o_rd_vld=0 in the next cycle and the partial word is discarded.
- o_overflow stays high until i_reset or i_flush.

## Test plan
- Default parameters, i_rd_rdy=1, write 8'b10010101 once:
  - o_rd_vld rises 2 cycles later;
  - o_hard_bit = 1,0,1,0,1,0,0,1 on 8 consecutive cycles;
  - then o_rd_vld=0 and o_empty=1.
- Back-pressure: write 8'b10101110 and toggle i_rd_rdy 1,0,0,1,... → o_hard_bit holds during ready-low cycles. Collected bits reassemble 8'hAE, with exactly 8 transfers.
- Fill with i_rd_rdy=0, write 18 words 0..17:
  - after 17 writes o_count=16 and o_full=1;
  - the 18th write sets o_overflow;
  - draining yields words 0..16 in order.
- Full + simultaneous pop: at o_count=16, write 8'hFF in the same cycle the last slice of the active word transfers → word accepted, o_count stays 16, o_overflow stays 0.
- Flush: assert i_flush during slice 3 of a word with 5 words queued and o_overflow=1 → next cycle o_rd_vld=0, o_count=0, o_empty=1, o_overflow=0. A write in the flush cycle is lost.
- OUT_WIDTH=4, LSB_FIRST=0, write 8'hA5 → two transfers: 4'hA then 4'h5. The next word follows with no gap.
